cp_remover: RTL
===============

// Module: cp_remover
// PURPOSE
// - Sits directly downstream of frame_sync, upstream of the FFT. Consumes time-domain samples plus symbol_start/CP_len
//   from frame_sync, strips the cyclic prefix and emits exactly FFT_LEN samples per OFDM symbol as a tlast-framed stream.
// - Tags each output symbol with PBCH/SSS flags so the FFT and demap stages can select SSB symbols without recounting.
// PARAMETERS
// - IN_DW       32   sample width (I/Q packed), passed through unchanged
// - FFT_LEN     256  samples per symbol emitted after CP removal
// - MAX_CP_LEN  20   largest CP length; sets CP_len_i width
// - CP_ADVANCE  2    CP samples kept at window start (STO margin); must be < CP2 length (18)
// - SYM_CNT_W   16   width of running symbol counter
// PORTS
// - clk_i             in   1                      clock
// - reset_i           in   1                      synchronous reset, active-high
// - s_axis_in_tdata   in   IN_DW                  input sample
// - s_axis_in_tvalid  in   1                      input sample valid; no backpressure
// - symbol_start_i    in   1                      first CP sample of a symbol is on the bus this cycle
// - CP_len_i          in   $clog2(MAX_CP_LEN)     CP length of the starting symbol, valid with symbol_start_i
// - PBCH_start_i      in   1                      tag next-starting symbol as PBCH
// - SSS_start_i       in   1                      tag next-starting symbol as SSS
// - m_axis_out_tdata  out  IN_DW                  CP-free sample
// - m_axis_out_tvalid out  1                      output valid
// - m_axis_out_tlast  out  1                      last (FFT_LEN-th) sample of symbol
// - m_axis_out_tuser  out  2                      {SSS, PBCH} tag, constant over a symbol
// - sym_cnt_o         out  SYM_CNT_W              symbols emitted since reset, wraps modulo 2^SYM_CNT_W
// - sym_err_o         out  1                      1-cycle pulse: symbol truncated by early symbol_start
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counters 0, tags cleared. Reset mid-symbol discards the symbol, no tlast issued.
// - symbol_start_i, PBCH_start_i, SSS_start_i are only honoured in cycles with s_axis_in_tvalid=1.
// - Tags: PBCH_start_i/SSS_start_i set sticky pending bits; on symbol_start pending bits move to the active tag and clear.
//   A tag pulse coinciding with symbol_start applies to that starting symbol.
// - FSM:
//   IDLE: wait for symbol_start_i. On it: skip = (CP_len_i > CP_ADVANCE) ? CP_len_i-CP_ADVANCE : 0; start sample counts
//     as skip sample #1 -> SKIP (skip>1), or it is emitted as out sample #1 -> PASS (skip=0), or SKIP ends -> PASS (skip=1).
//   SKIP: drop valid samples until skip count reached, then PASS.
//   PASS: forward each valid sample; out counter 0..FFT_LEN-1; at count FFT_LEN-1 assert tlast, sym_cnt_o+1, -> IDLE.
//     Samples between tlast and next symbol_start (CP_ADVANCE tail samples) are dropped.
// - Latency: 1 cycle, input sample registered to output; tvalid/tlast/tuser aligned with tdata.
// - Early symbol_start in SKIP or PASS: current symbol aborted, sym_err_o pulses next cycle, no tlast for it,
//   sym_cnt_o not incremented; new symbol starts on the same cycle (restart as from IDLE).
// - symbol_start_i coinciding with the tlast sample: tlast completes normally, new symbol starts same cycle, no error.
// - Invalid-cycle gaps inside a symbol: counters hold; output tvalid low.
// - tuser held for every sample of the symbol including tlast.
// STRUCTURE
// - Shared package (frame_pkg): FFT_LEN, CP1_LEN=20, CP2_LEN=18, MAX_CP_LEN, SYM_PER_SF=14, tuser bit indices
//   (TUSER_PBCH=0, TUSER_SSS=1); frame_sync and cp_remover both import it.
// - Single module, no sub-modules; 3-state enum FSM plus skip/out counters.
// TESTING
// - CP_ADVANCE=2, symbol_start with CP_len=20, 276 continuous samples -> samples 19..274 emitted, tlast on 274, sym_cnt_o=1.
// - 14 back-to-back symbols (CP 20,18x6,20,18x6) -> 14 x 256-sample frames, no sym_err_o, tail 2 samples dropped each.
// - PBCH_start_i 5 cycles before a symbol_start -> that symbol tuser=01, following symbol tuser=00.
// - symbol_start after 100 PASS samples -> sym_err_o pulse, no tlast, new symbol emits full 256 with tlast.
// - tvalid toggling 50% during a symbol -> output identical sample sequence, tlast on 256th valid output.
// - reset_i asserted mid-PASS -> tvalid=0 next cycle, sym_cnt_o=0; next symbol_start yields a clean full symbol.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared frame-timing constants and types for frame_sync and cp_remover.
package frame_pkg;

  localparam int unsigned FFT_LEN    = 256;
  localparam int unsigned CP1_LEN    = 20;
  localparam int unsigned CP2_LEN    = 18;
  localparam int unsigned MAX_CP_LEN = 20;
  localparam int unsigned SYM_PER_SF = 14;

  // tuser bit positions: {SSS, PBCH}
  localparam int unsigned TUSER_PBCH = 0;
  localparam int unsigned TUSER_SSS  = 1;
  localparam int unsigned TUSER_W    = 2;

  typedef enum logic [1:0] {
    CP_IDLE,
    CP_SKIP,
    CP_PASS
  } cp_state_e;

endpackage

// File: rtl/cp_remover.sv
// Strips the cyclic prefix (keeping CP_ADVANCE samples of margin) and emits
// FFT_LEN-sample tlast-framed symbols tagged with PBCH/SSS flags.
module cp_remover #(
  parameter int unsigned IN_DW      = 32,
  parameter int unsigned FFT_LEN    = frame_pkg::FFT_LEN,
  parameter int unsigned MAX_CP_LEN = frame_pkg::MAX_CP_LEN,
  parameter int unsigned CP_ADVANCE = 2,
  parameter int unsigned SYM_CNT_W  = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [IN_DW-1:0]              s_axis_in_tdata,
  input  logic                          s_axis_in_tvalid,
  input  logic                          symbol_start_i,
  input  logic [$clog2(MAX_CP_LEN)-1:0] CP_len_i,
  input  logic                          PBCH_start_i,
  input  logic                          SSS_start_i,
  output logic [IN_DW-1:0]              m_axis_out_tdata,
  output logic                          m_axis_out_tvalid,
  output logic                          m_axis_out_tlast,
  output logic [1:0]                    m_axis_out_tuser,
  output logic [SYM_CNT_W-1:0]          sym_cnt_o,
  output logic                          sym_err_o
);
  import frame_pkg::*;

  localparam int unsigned CP_W  = $clog2(MAX_CP_LEN);
  localparam int unsigned OUT_W = $clog2(FFT_LEN);

  cp_state_e            state_q, state_d;
  logic [CP_W-1:0]      skip_cnt_q, skip_cnt_d;
  logic [CP_W-1:0]      skip_tgt_q, skip_tgt_d;
  logic [OUT_W-1:0]     out_cnt_q, out_cnt_d;
  logic [TUSER_W-1:0]   pend_q, pend_d;
  logic [TUSER_W-1:0]   tag_q, tag_d;
  logic [SYM_CNT_W-1:0] sym_cnt_q, sym_cnt_d;
  logic [IN_DW-1:0]     tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
  logic [TUSER_W-1:0]   tuser_q, tuser_d;
  logic                 err_q, err_d;
  logic [TUSER_W-1:0]   tag_pulse;
  logic [CP_W-1:0]      skip_len;

  // Current symbol is advanced first; a symbol_start then (re)starts a new one on the same sample.
  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    skip_tgt_d = skip_tgt_q;
    out_cnt_d  = out_cnt_q;
    pend_d     = pend_q;
    tag_d      = tag_q;
    sym_cnt_d  = sym_cnt_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    tlast_d    = 1'b0;
    tuser_d    = tuser_q;
    err_d      = 1'b0;

    tag_pulse             = '0;
    tag_pulse[TUSER_PBCH] = PBCH_start_i;
    tag_pulse[TUSER_SSS]  = SSS_start_i;
    skip_len = (CP_len_i > CP_W'(CP_ADVANCE)) ? CP_len_i - CP_W'(CP_ADVANCE) : '0;

    if (s_axis_in_tvalid) begin
      pend_d = pend_q | tag_pulse;

      case (state_q)
        CP_SKIP: begin
          if (symbol_start_i) begin
            err_d = 1'b1;
          end else begin
            skip_cnt_d = skip_cnt_q + 1'b1;
            if (skip_cnt_d == skip_tgt_q) state_d = CP_PASS;
          end
        end
        CP_PASS: begin
          if (symbol_start_i && (out_cnt_q != OUT_W'(FFT_LEN - 1))) begin
            err_d = 1'b1;
          end else begin
            tvalid_d = 1'b1;
            tdata_d  = s_axis_in_tdata;
            tuser_d  = tag_q;
            if (out_cnt_q == OUT_W'(FFT_LEN - 1)) begin
              tlast_d   = 1'b1;
              out_cnt_d = '0;
              sym_cnt_d = sym_cnt_q + 1'b1;
              state_d   = CP_IDLE;
            end else begin
              out_cnt_d = out_cnt_q + 1'b1;
            end
          end
        end
        default: ;
      endcase

      if (symbol_start_i) begin
        tag_d      = pend_d;
        pend_d     = '0;
        skip_cnt_d = CP_W'(1);
        skip_tgt_d = skip_len;
        out_cnt_d  = '0;
        if (skip_len == '0) begin
          state_d = CP_PASS;
          // A start sample already used as the previous tlast cannot be emitted twice.
          if (!tlast_d) begin
            tvalid_d  = 1'b1;
            tdata_d   = s_axis_in_tdata;
            tuser_d   = tag_d;
            out_cnt_d = OUT_W'(1);
          end
        end else if (skip_len == CP_W'(1)) begin
          state_d = CP_PASS;
        end else begin
          state_d = CP_SKIP;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= CP_IDLE;
      skip_cnt_q <= '0;
      skip_tgt_q <= '0;
      out_cnt_q  <= '0;
      pend_q     <= '0;
      tag_q      <= '0;
      sym_cnt_q  <= '0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      tlast_q    <= 1'b0;
      tuser_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
      skip_tgt_q <= skip_tgt_d;
      out_cnt_q  <= out_cnt_d;
      pend_q     <= pend_d;
      tag_q      <= tag_d;
      sym_cnt_q  <= sym_cnt_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      tlast_q    <= tlast_d;
      tuser_q    <= tuser_d;
      err_q      <= err_d;
    end
  end

  assign m_axis_out_tdata  = tdata_q;
  assign m_axis_out_tvalid = tvalid_q;
  assign m_axis_out_tlast  = tlast_q;
  assign m_axis_out_tuser  = tuser_q;
  assign sym_cnt_o         = sym_cnt_q;
  assign sym_err_o         = err_q;

endmodule
